// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a byte FIFO on the write side.
// The CPU/MMIO side pushes bytes with uart_fifo_write_en/uart_fifo_data.
// The serialiser sends each byte LSB-first at CLOCK_FREQ/BAUD_RATE clocks per bit.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the data bits and the stop bit. The default build is plain 8N1.
module uart_tx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DEPTH      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_fifo_write_en,
    input  logic [7:0] uart_fifo_data,
    output logic       tx_line,
    output logic       tx_ready,
    output logic       write_fifo_full,
    output logic       tx_busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int PTR_W        = $clog2(DEPTH);
    localparam int CNT_W        = PTR_W + 1;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    logic fifo_empty;
    logic baud_done;
    logic push;
    logic pop;

    assign fifo_empty = (count == '0);
    assign baud_done  = (baud_cnt == BAUD_LAST);
    // Fullness is judged on the count at the start of the cycle, so a write
    // arriving while full is dropped even if a pop happens in the same cycle.
    assign push       = uart_fifo_write_en && (count != CNT_FULL);
    assign pop        = !fifo_empty &&
                        ((state == IDLE) || ((state == STOP) && baud_done));

    assign tx_ready   = fifo_empty && !tx_busy;

    // Next FIFO occupancy from this cycle's push/pop pair
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= uart_fifo_data;
        end
    end

    // FIFO pointers, occupancy and the registered full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            write_fifo_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count           <= count_next;
            write_fifo_full <= (count_next == CNT_FULL);
        end
    end

    // Frame sequencer with registered line and busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            tx_line    <= 1'b1;
            tx_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx_line <= 1'b1;
                    if (pop) begin
                        shift      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        baud_cnt   <= '0;
                        state      <= START;
                        tx_line    <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end

                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx_line  <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                // The line is loaded with the next bit one edge ahead of the
                // shift so tx_line stays a pure register output.
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx_line <= parity_bit;
`else
                            state   <= STOP;
                            tx_line <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_line <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        tx_line  <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift      <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^mem[rd_ptr];
`endif
                            state      <= START;
                            tx_line    <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            tx_line    <= 1'b1;
                            tx_busy    <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                    tx_line  <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven bench for uart_tx (8N1, or with
// UART_TX_PARITY_EN defined the 11-bit even-parity frame).
module tb_uart_tx;

    localparam int CLOCK_FREQ = 50_000_000;
    localparam int BAUD_RATE  = 115200;
    localparam int DEPTH      = 8;
    localparam int C          = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int NB         = 11;
`else
    localparam int NB         = 10;
`endif
    localparam int FRAME      = NB * C;
    localparam int BUDGET     = 3 * FRAME;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       tx_line;
    logic       tx_ready;
    logic       write_fifo_full;
    logic       tx_busy;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    uart_tx #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .uart_fifo_write_en(wr_en),
        .uart_fifo_data    (wr_data),
        .tx_line           (tx_line),
        .tx_ready          (tx_ready),
        .write_fifo_full   (write_fifo_full),
        .tx_busy           (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Frame words: bit0 = start, bits 1..8 = data LSB first, then parity/stop.
    typedef struct {
        logic [7:0]  data;
        logic [10:0] exp_8n1;
        logic [10:0] exp_par;
    } vec_t;

    vec_t vecs[3];

    function automatic logic [10:0] exp_of(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return v.exp_par;
`else
        return v.exp_8n1;
`endif
    endfunction

    function automatic logic [10:0] model_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Waits (bounded) for a start bit, then samples every bit at mid-bit.
    task automatic recv_frame(input logic [10:0] exp, input string nm, output int t0);
        int n = 0;
        logic [10:0] got = '0;
        while (tx_line !== 1'b0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        chk({nm, "_start_seen"}, n < BUDGET, 1);
        if (n < BUDGET) begin
            repeat (C / 2) @(negedge clk);
            for (int k = 0; k < NB; k++) begin
                got[k] = tx_line;
                if (k < NB - 1) repeat (C) @(negedge clk);
            end
            chk(nm, got, exp);
        end
    endtask

    task automatic wait_ready(input string nm, output int t);
        int n = 0;
        while (tx_ready !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        chk({nm, "_ready_seen"}, n < BUDGET, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t0, t1, t2, tr, ts, lows;

        vecs[0] = '{8'h5A, 11'b0_1_01011010_0, 11'b1_0_01011010_0};
        vecs[1] = '{8'h07, 11'b0_1_00000111_0, 11'b1_1_00000111_0};
        vecs[2] = '{8'h03, 11'b0_1_00000011_0, 11'b1_0_00000011_0};

        do_reset();
        chk("rst_tx_line", tx_line, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_full", write_fifo_full, 0);
        chk("rst_tx_busy", tx_busy, 0);

        // Single bytes: latency, bit order, parity and frame length
        for (int v = 0; v < 3; v++) begin
            wr_en   = 1'b1;
            wr_data = vecs[v].data;
            @(negedge clk);
            wr_en = 1'b0;
            chk("wr_line_still_idle", tx_line, 1);
            chk("wr_ready_drops", tx_ready, 0);
            chk("wr_busy_still_low", tx_busy, 0);
            @(negedge clk);
            chk("start_after_one_cycle", tx_line, 0);
            chk("busy_in_frame", tx_busy, 1);
            recv_frame(exp_of(vecs[v]), "single_frame", t0);
            wait_ready("single", tr);
            chk("single_frame_len", tr - t0, FRAME);
            @(negedge clk);
        end

        // Back-to-back: three frames with no idle gap
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_data = 8'hFF;
        @(negedge clk);
        chk("b2b_start_low", tx_line, 0);
        ts = cyc;
        wr_data = 8'h55;
        @(negedge clk);
        wr_en = 1'b0;
        recv_frame(model_frame(8'h5A), "b2b_frame0", t0);
        recv_frame(model_frame(8'hFF), "b2b_frame1", t1);
        recv_frame(model_frame(8'h55), "b2b_frame2", t2);
        chk("b2b_gap01", t1 - ts, FRAME);
        chk("b2b_gap12", t2 - t1, FRAME);
        wait_ready("b2b", tr);
        chk("b2b_total", tr - ts, 3 * FRAME);
        @(negedge clk);

        // Overflow: ten consecutive writes, the tenth is dropped
        do_reset();
        wr_en   = 1'b1;
        wr_data = 8'h00;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 2) begin
                chk("ovf_start_low", tx_line, 0);
                ts = cyc;
            end
            if (i == 8) chk("ovf_not_full_at_7", write_fifo_full, 0);
            if (i == 9) chk("ovf_full_after_9th", write_fifo_full, 1);
            wr_data = 8'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("ovf_full_after_drop", write_fifo_full, 1);
        for (int k = 0; k <= 8; k++) begin
            recv_frame(model_frame(8'(k)), "ovf_frame", t1);
            if (k == 1) chk("ovf_full_clears", write_fifo_full, 0);
        end
        wait_ready("ovf", tr);
        chk("ovf_total_nine_frames", tr - ts, 9 * FRAME);
        @(negedge clk);

        // Reset during data bit 3 of 0xA5
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        chk("rmid_start_low", tx_line, 0);
        repeat (4 * C + C / 2) @(negedge clk);
        chk("rmid_bit3_low", tx_line, 0);
        chk("rmid_busy", tx_busy, 1);
        rst = 1'b1;
        #1;
        chk("rmid_line_async", tx_line, 1);
        chk("rmid_ready_async", tx_ready, 1);
        chk("rmid_busy_async", tx_busy, 0);
        chk("rmid_full_async", write_fifo_full, 0);
        @(negedge clk);
        rst  = 1'b0;
        lows = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (tx_line !== 1'b1) lows++;
        end
        chk("rmid_line_stays_idle", lows, 0);
        chk("rmid_ready_after", tx_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
